posit_div_pack: RTL and testbench

Pipelined posit packing stage directly downstream of the division arithmetic block (`Div`). It takes the normalised quotient mantissa, the sign, the special-case flags and the combined scale (`Total_EO`) and assembles a rounded N-bit posit. The assembly covers regime run-length encoding, exponent insertion, fraction truncation, round-to-nearest-even, saturation and two's-complement for negative results. The stage is elastic with a valid/ready handshake in and out, latency 2, and accepts one operation per cycle.

---
 rtl/posit_div_pack.sv | 140 ++++++++++++++
 tb/tb_posit_div_pack.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/posit_div_pack.sv
`default_nettype none
// ============================================================================
// Module   : posit_div_pack
// Purpose  : Two-stage elastic packing stage after the posit divider. Turns
//            the normalised quotient, sign, special flags and total scale
//            into a rounded N-bit posit (regime encoding, exponent insertion,
//            round-to-nearest-even, saturation, two's complement).
// Ports    : clk, rst (sync, active high)
//            in_valid/in_ready   - upstream handshake
//            Sign, inf, zero     - result sign and special-case flags
//            Div_Mant_N [2N-1:0] - quotient, bit 2N-1 hidden one, bit 0 sticky
//            Total_EO            - signed scale k*2^ES + e
//            out_valid/out_ready - downstream handshake
//            Result [N-1:0]      - packed posit
// Revision : 1.0 - initial release
// ============================================================================
module posit_div_pack #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  Sign,
  input  logic                  inf,
  input  logic                  zero,
  input  logic [2*N-1:0]        Div_Mant_N,
  input  logic [RS+ES+4:0]      Total_EO,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          Result
);

  localparam int TW = RS + ES + 5;
  // Stream = run bit, terminator, exponent, fraction, then padding so that
  // bits pushed right by the regime are never lost from the sticky.
  localparam int YW = 2 + ES + (2 * N - 1) + N;
  localparam logic signed [TW-1:0] K_HI = TW'(N - 2);
  localparam logic signed [TW-1:0] K_LO = TW'(-(N - 1));

  // ---------------------------------------------------------------- stage 1
  logic signed [TW-1:0] w_k;
  logic [TW-1:0]        w_shamt;
  logic                 w_run_bit;
  logic [YW-1:0]        w_y;
  logic [YW-1:0]        w_sh;

  logic                 r_s1_valid;
  logic [N-2:0]         r_body;
  logic                 r_guard;
  logic                 r_sticky;
  logic                 r_sign;
  logic                 r_inf;
  logic                 r_zero;
  logic                 r_sat_hi;
  logic                 r_sat_lo;

  logic                 r_s2_valid;
  logic [N-1:0]         r_result;

  logic                 w_s2_take;
  logic                 w_accept;

  assign w_k       = $signed(Total_EO) >>> ES;
  assign w_run_bit = ~w_k[TW-1];
  // Regime run length minus one: k for k >= 0, -k-1 (= ~k) for k < 0.
  assign w_shamt   = w_k[TW-1] ? ~w_k : w_k;
  assign w_y       = {w_run_bit, ~w_run_bit, Total_EO[ES-1:0],
                      Div_Mant_N[2*N-2:0], {N{1'b0}}};
  // Arithmetic shift replicates the run bit, producing the full regime.
  assign w_sh      = $unsigned($signed(w_y) >>> w_shamt);

  // ---------------------------------------------------------------- handshake
  assign w_s2_take = ~r_s2_valid | out_ready;
  assign in_ready  = ~rst & (~r_s1_valid | w_s2_take);
  assign w_accept  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_body   <= w_sh[YW-1 -: N-1];
      r_guard  <= w_sh[YW-N];
      r_sticky <= |w_sh[YW-N-1:0];
      r_sign   <= Sign;
      r_inf    <= inf;
      r_zero   <= zero;
      r_sat_hi <= (w_k >= K_HI);
      r_sat_lo <= (w_k <= K_LO);
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic         w_rnd;
  logic [N-1:0] w_sum;
  logic [N-2:0] w_body_r;
  logic [N-1:0] w_mag;
  logic [N-1:0] w_res;

  assign w_rnd = r_guard & (r_sticky | r_body[0]);
  assign w_sum = {1'b0, r_body} + {{(N-1){1'b0}}, w_rnd};

  always_comb begin
    w_body_r = w_sum[N-2:0];
    if (w_sum[N-1]) w_body_r = {(N-1){1'b1}};   // clamp at maxpos, never NaR
    if (r_sat_hi)   w_body_r = {(N-1){1'b1}};
    if (r_sat_lo)   w_body_r = {{(N-2){1'b0}}, 1'b1};  // minpos, never zero
  end

  assign w_mag = {1'b0, w_body_r};

  always_comb begin
    w_res = r_sign ? (~w_mag + {{(N-1){1'b0}}, 1'b1}) : w_mag;
    if (r_zero) w_res = '0;
    if (r_inf)  w_res = {1'b1, {(N-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
    end else if (w_s2_take) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_result <= w_res;
    end
  end

  assign out_valid = r_s2_valid & ~rst;
  assign Result    = rst ? '0 : r_result;

endmodule
`default_nettype wire

// File: tb/tb_posit_div_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_posit_div_pack
// Purpose  : Directed self-checking bench for posit_div_pack (N=32, ES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_posit_div_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        Sign;
  logic        inf;
  logic        zero;
  logic [63:0] Div_Mant_N;
  logic [11:0] Total_EO;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] ONE = 64'h8000_0000_0000_0000;

  posit_div_pack #(.N(32), .ES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Sign       (Sign),
    .inf        (inf),
    .zero       (zero),
    .Div_Mant_N (Div_Mant_N),
    .Total_EO   (Total_EO),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic i, input logic z,
                        input logic [63:0] m, input logic [11:0] t);
    Sign = s; inf = i; zero = z; Div_Mant_N = m; Total_EO = t;
  endtask

  // Single transfer with out_ready high; returns result and edge count
  // from the accept cycle until out_valid (99 on timeout).
  task automatic xfer(input logic s, input logic i, input logic z,
                      input logic [63:0] m, input logic [11:0] t,
                      output logic [31:0] res, output int lat);
    int w;
    out_ready = 1'b1;
    set_in(s, i, z, m, t);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 10) begin tick(); w++; end
    lat = 99;
    res = 'x;
    if (in_ready) begin
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin tick(); lat++; end
      if (!out_valid) lat = 99;
      res = Result;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (Result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=00000000", Result); end
    rst = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] r; int lat;
    xfer(1'b0, 1'b0, 1'b0, ONE, 12'd0, r, lat);
    total++; if (r !== 32'h40000000) begin bad++; $display("FAIL one got=%h exp=40000000", r); end
    total++; if (lat !== 2) begin bad++; $display("FAIL latency got=%0d exp=2", lat); end
    xfer(1'b0, 1'b0, 1'b0, ONE, -12'sd2, r, lat);
    total++; if (r !== 32'h30000000) begin bad++; $display("FAIL quarter got=%h exp=30000000", r); end
    xfer(1'b1, 1'b0, 1'b0, ONE, -12'sd2, r, lat);
    total++; if (r !== 32'hD0000000) begin bad++; $display("FAIL neg_quarter got=%h exp=D0000000", r); end
  endtask

  task automatic test_round();
    logic [31:0] r; int lat;
    xfer(1'b0, 1'b0, 1'b0, 64'h8000_0008_0000_0000, 12'd0, r, lat);
    total++; if (r !== 32'h40000000) begin bad++; $display("FAIL tie_even got=%h exp=40000000", r); end
    xfer(1'b0, 1'b0, 1'b0, 64'h8000_0018_0000_0000, 12'd0, r, lat);
    total++; if (r !== 32'h40000002) begin bad++; $display("FAIL tie_odd got=%h exp=40000002", r); end
    xfer(1'b0, 1'b0, 1'b0, 64'h8000_0008_0000_0001, 12'd0, r, lat);
    total++; if (r !== 32'h40000001) begin bad++; $display("FAIL sticky got=%h exp=40000001", r); end
  endtask

  task automatic test_sat();
    logic [31:0] r; int lat;
    xfer(1'b0, 1'b0, 1'b0, ONE, 12'sd200, r, lat);
    total++; if (r !== 32'h7FFFFFFF) begin bad++; $display("FAIL sat_hi got=%h exp=7FFFFFFF", r); end
    xfer(1'b0, 1'b0, 1'b0, ONE, -12'sd200, r, lat);
    total++; if (r !== 32'h00000001) begin bad++; $display("FAIL sat_lo got=%h exp=00000001", r); end
    xfer(1'b1, 1'b0, 1'b0, ONE, -12'sd200, r, lat);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL sat_lo_neg got=%h exp=FFFFFFFF", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat;
    xfer(1'b0, 1'b1, 1'b1, ONE, 12'd0, r, lat);
    total++; if (r !== 32'h80000000) begin bad++; $display("FAIL nar got=%h exp=80000000", r); end
    xfer(1'b1, 1'b1, 1'b0, ONE, 12'd5, r, lat);
    total++; if (r !== 32'h80000000) begin bad++; $display("FAIL nar_neg got=%h exp=80000000", r); end
    xfer(1'b1, 1'b0, 1'b1, ONE, 12'd0, r, lat);
    total++; if (r !== 32'h00000000) begin bad++; $display("FAIL zero_neg got=%h exp=00000000", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [3];
    logic [11:0] teo_q [3];
    logic        sg_q  [3];
    logic [31:0] got   [8];
    int idx, n, w;
    logic acc, held_ok;
    exp_q = '{32'h40000000, 32'h30000000, 32'hD0000000};
    teo_q = '{12'd0, -12'sd2, -12'sd2};
    sg_q  = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b0;
    idx = 0;
    set_in(sg_q[0], 1'b0, 1'b0, ONE, teo_q[0]);
    in_valid = 1'b1;
    w = 0;
    while (idx < 2 && w < 10) begin
      acc = in_valid & in_ready;
      tick(); w++;
      if (acc) begin idx++; set_in(sg_q[idx], 1'b0, 1'b0, ONE, teo_q[idx]); end
    end
    total++; if (idx !== 2) begin bad++; $display("FAIL bp_accepts got=%0d exp=2", idx); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    // Held output must stay stable; scribble on the inputs meanwhile.
    held_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 1'b1, 1'b0, '1, 12'd7);
      if (!(out_valid === 1'b1 && Result === exp_q[0])) held_ok = 1'b0;
      tick();
    end
    set_in(sg_q[2], 1'b0, 1'b0, ONE, teo_q[2]);
    total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL bp_hold got=%h exp=%h", Result, exp_q[0]); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_ready got=%b exp=1", in_ready); end
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        if (n < 8) got[n] = Result;
        n++;
      end
      acc = in_valid & in_ready;
      tick();
      if (acc) begin idx++; in_valid = 1'b0; end
    end
    total++; if (n !== 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", n); end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (n <= j || got[j] !== exp_q[j]) begin
        bad++; $display("FAIL bp_order[%0d] got=%h exp=%h", j, (n > j) ? got[j] : 32'hx, exp_q[j]);
      end
    end
  endtask

  task automatic test_reset_flight();
    int w, seen;
    out_ready = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, ONE, 12'd0);
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_flight_valid got=%b exp=0", out_valid); end
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (w = 0; w < 5; w++) begin
      if (out_valid) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_flight_emit got=%0d exp=0", seen); end
    total++; if (Result !== 32'h0) begin bad++; $display("FAIL rst_flight_result got=%h exp=00000000", Result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_sat();
    test_special();
    test_back_to_back();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
